// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential multiplier controller.
//   - state_t    : controller states (encoding 2'd3 is illegal, recovers to IDLE)
//   - MULT_STEPS : number of shift-and-add steps per multiply
//   - PROD_W     : product / adder width
package arith_pkg;

    localparam int MULT_STEPS = 8;
    localparam int PROD_W     = 16;
    localparam int CNT_W      = $clog2(MULT_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Handshake/operand bundle for seq_mult_ctrl.
//   start   : request, honoured only in IDLE or DONE
//   a, b    : multiplicand / multiplier, captured on the accepted-start edge
//   busy    : high while multiplying
//   done    : one-cycle result pulse
//   product : result, held until the next accepted start
// master = requester side, slave = multiplier side.
interface seq_mult_ctrl_if;
    import arith_pkg::*;

    logic              start;
    logic [7:0]        a;
    logic [7:0]        b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/adder_16bit.sv
// 16-bit gate-level ripple-carry adder used as the accumulate engine.
//   sum   : x + y + cin (low 16 bits)
//   carry : carry-out of every bit position; carry[15] is the overall carry-out
//   x, y  : addends
//   cin   : carry-in to bit 0
module adder_16bit (
    output logic [15:0] sum,
    output logic [15:0] carry,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin
);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_fa
            logic ci;
            logic co;
            logic p;

            // Carries are chained through per-stage scalars so the
            // ripple path is not a self-referencing vector.
            if (gi == 0) begin : g_first
                assign ci = cin;
            end else begin : g_rest
                assign ci = g_fa[gi-1].co;
            end

            assign p         = x[gi] ^ y[gi];
            assign sum[gi]   = p ^ ci;
            assign co        = (x[gi] & y[gi]) | (p & ci);
            assign carry[gi] = co;
        end
    endgenerate

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier controller.
// One adder_16bit is reused for 8 fixed steps, one partial product per cycle.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset; discards any in-flight multiply
//   mif  : slave side of seq_mult_ctrl_if (start/a/b in, busy/done/product out)
// Latency: start accepted at edge k -> busy in cycles k+1..k+8, done in k+9.
module seq_mult_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_mult_ctrl_if.slave mif
);

    state_t               state_reg,  state_next;
    logic [2*WIDTH-1:0]   mcand_reg,  mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic [PROD_W-1:0]    acc_reg,    acc_next;
    logic [CNT_W-1:0]     cnt_reg,    cnt_next;

    logic [PROD_W-1:0]    addend;
    logic [PROD_W-1:0]    sum;
    logic [PROD_W-1:0]    carry;
    logic                 carry_unused;

    // Partial product: the shifted multiplicand is added only when the
    // current multiplier LSB is set.
    assign addend = mplier_reg[0] ? mcand_reg : '0;

    adder_16bit u_adder (
        .sum   (sum),
        .carry (carry),
        .x     (acc_reg),
        .y     (addend),
        .cin   (1'b0)
    );

    // Internal carries are not part of the result.
    assign carry_unused = ^carry[PROD_W-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (mif.start) begin
                    mcand_next  = {{WIDTH{1'b0}}, mif.a};
                    mplier_next = mif.b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end

            RUN: begin
                // start is deliberately not looked at here: no queueing, no abort.
                acc_next    = sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                // Fixed step count, no early exit when the multiplier empties.
                if (cnt_reg == CNT_W'(MULT_STEPS - 1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                // A start here chains straight into the next multiply.
                if (mif.start) begin
                    mcand_next  = {{WIDTH{1'b0}}, mif.a};
                    mplier_next = mif.b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs, decoded from state only.
    assign mif.busy    = (state_reg == RUN);
    assign mif.done    = (state_reg == DONE);
    assign mif.product = acc_reg;

    // An 8x8 product never exceeds 16'hFE01, so the adder can never carry out.
    a_no_carry_out : assert property (
        @(posedge clk) disable iff (rst) (state_reg == RUN) |-> !carry[PROD_W-1]
    );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

    logic clk;
    logic rst;

    seq_mult_ctrl_if mif ();

    seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    int busy_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (mif.busy && mif.done) check("busy_done_overlap", 1, 0);
            if (mif.busy) begin
                busy_run++;
            end else if (mif.done) begin
                check("busy_len", busy_run, 8);
                busy_run = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    $display("result: product=%h expected=%h", mif.product, e);
                    check("product", {16'h0, mif.product}, {16'h0, e});
                end
            end else begin
                busy_run = 0;
            end
        end else begin
            busy_run = 0;
        end
    end

    // Single op from IDLE/DONE; checks busy window, done timing and hold.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ev);
        mif.a = av;
        mif.b = bv;
        mif.start = 1'b1;
        exp_q.push_back(ev);
        $display("issue: a=%h b=%h expect=%h", av, bv, ev);
        step();
        mif.start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("busy_in_run", {31'h0, mif.busy}, 1);
            step();
        end
        check("done_at_k9", {30'h0, mif.done, mif.busy}, 2'b10);
        step();
        check("held_product", {15'h0, mif.done, mif.product}, {16'h0, ev});
    endtask

    initial begin
        rst = 1'b1;
        mif.start = 1'b0;
        mif.a = 8'h00;
        mif.b = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        mif.a = 8'hFF;
        mif.b = 8'hFF;

        // Reset / idle with start low.
        for (int i = 0; i < 20; i++) begin
            check("reset_idle", {14'h0, mif.product, mif.busy, mif.done}, 32'h0);
            step();
        end

        // Basic and max-operand multiplies.
        run_op(8'd13, 8'd11, 16'h008F);
        run_op(8'hFF, 8'hFF, 16'hFE01);

        // Zero product with an ignored start in RUN cycle 3.
        mif.a = 8'h00;
        mif.b = 8'hFF;
        mif.start = 1'b1;
        exp_q.push_back(16'h0000);
        $display("issue: a=00 b=ff expect=0000 (start pulse in RUN ignored)");
        step();
        mif.start = 1'b0;
        step();
        step();
        mif.a = 8'h02;
        mif.b = 8'h03;
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        repeat (5) step();
        check("zero_done", {31'h0, mif.done}, 1);
        repeat (12) step();
        check("zero_held", {16'h0, mif.product}, 32'h0);

        // Back-to-back through DONE with start held high.
        mif.a = 8'd7;
        mif.b = 8'd9;
        mif.start = 1'b1;
        exp_q.push_back(16'h003F);
        $display("issue: a=07 b=09 expect=003f");
        step();
        repeat (8) step();
        check("b2b_first_done", {31'h0, mif.done}, 1);
        mif.a = 8'd5;
        mif.b = 8'd5;
        exp_q.push_back(16'h0019);
        $display("issue: a=05 b=05 expect=0019 (back-to-back)");
        step();
        mif.start = 1'b0;
        check("b2b_no_idle", {31'h0, mif.busy}, 1);
        repeat (8) step();
        check("b2b_second_done", {31'h0, mif.done}, 1);
        step();

        // Mid-operation reset at RUN cycle 4.
        mif.a = 8'd200;
        mif.b = 8'd100;
        mif.start = 1'b1;
        $display("issue: a=c8 b=64 (aborted by reset)");
        step();
        mif.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("reset_mid_run", {14'h0, mif.product, mif.busy, mif.done}, 32'h0);
        rst = 1'b0;
        repeat (12) step();
        check("no_done_after_abort", {31'h0, mif.done}, 0);
        run_op(8'd3, 8'd4, 16'h000C);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

- Sequential shift-and-add multiplier controller: one 8×8 unsigned multiply per start.
- Operands are captured once, then one existing `adder_16bit` instance is sequenced over 8 cycles, one partial product per cycle.
- Sits above the gate-level adder datapath. Makes that adder the accumulate engine for arithmetic blocks that have no room for a parallel multiplier.

## Interface

- `WIDTH`, default 8: operand width. Product is 2·WIDTH = 16, matching the adder. Only 8 is supported.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only when the FSM is in IDLE or DONE.
- `a`  in  8  multiplicand; captured on the accepted-start edge.
- `b`  in  8  multiplier; captured on the accepted-start edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; high while in DONE.
- `product`  out  16  result. Valid while `done` is high, and held until the next accepted start.

## Operation

- **Registers**
  - `mcand` (16b): {8'b0, a}, shifted left by 1 each RUN cycle.
  - `mplier` (8b): b, shifted right by 1 each RUN cycle.
  - `acc` (16b): accumulator.
  - `cnt` (3b): step counter.
  - `state`: current FSM state.
- **Datapath:** `adder_16bit` instance, ports in order (sum, carry, x, y, cin).
  - x = `acc`.
  - y = `mcand` when `mplier[0]`=1, else 16'h0000.
  - cin = 0.
  - The carry vector is unused except bit 15, which feeds an assertion only.
- **IDLE**
  - On `start`=1: capture operands, `acc`←0, `cnt`←0, next state RUN.
  - Otherwise remain in IDLE.
- **RUN**
  - Each cycle: `acc`←adder sum, `mcand`←`mcand`<<1, `mplier`←`mplier`>>1, `cnt`←`cnt`+1.
  - After the step with `cnt`=7, next state DONE.
  - There is no early exit when `mplier` reaches 0; the step count is fixed at 8.
- **DONE**
  - `done`=1 and `product`=`acc`.
  - If `start`=1: capture new operands, clear `acc`/`cnt`, next state RUN (back-to-back).
  - Otherwise next state IDLE.
- `start` during RUN is ignored; it is neither queued nor able to abort the multiply.
- `product` is driven directly from `acc`. In IDLE it keeps the last result.
- **Width rule:** an 8×8 product is at most 16'hFE01, so adder carry bit 15 is never 1. Assertion: carry[15]==0 in every RUN cycle.
- **Reset** at any time, including mid-RUN: state→IDLE, `acc`/`mcand`/`mplier`/`cnt`→0. The in-flight operation is discarded and no `done` pulse is produced.

## Timing

- Reset values: `busy`=0, `done`=0, `product`=16'h0000.
- Start accepted at edge k:
  - `busy` is high for cycles k+1..k+8.
  - `done` is high in cycle k+9.
  - Latency is 9 cycles start-to-done.
- Throughput:
  - Back-to-back via DONE: one result per 9 cycles.
  - Via IDLE: one result per 10 cycles.
- `busy` and `done` are never high simultaneously. They are Moore outputs, decoded from `state` only.
- The adder is a combinational ripple path between registers: 16 stages plus mask, inside one cycle.

## Structure

- Shared package `arith_pkg` holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE on the next edge.
  - `MULT_STEPS`=8.
  - `PROD_W`=16.
- Sub-module: the existing `adder_16bit`, instanced once; it is not modified.
- The controller FSM and shift registers stay flat in `seq_mult_ctrl`.

## Test plan

- **Reset:** after reset, a=8'hFF, b=8'hFF, `start` held low for 20 cycles → `product`=16'h0000, `busy`=0, `done`=0 throughout.
- **Basic:** a=8'd13, b=8'd11, one-cycle `start` → `busy` for exactly 8 cycles, `done` pulse at start+9, `product`=16'h008F held afterwards.
- **Max operands:** a=8'hFF, b=8'hFF → `product`=16'hFE01 at `done`; the carry[15] assertion never fires.
- **Zero / ignored start:** a=0, b=8'hFF → `product`=0. Pulsing `start` with a=8'h02, b=8'h03 at RUN cycle 3 is ignored; the result is still 0 and only one `done` occurs.
- **Back-to-back:** `start` held high continuously with a=7, b=9, then a=5, b=5 presented in the DONE cycle → first `done` gives 16'h003F. The second op starts without passing through IDLE and its `done` appears 9 cycles later with 16'h0019.
- **Mid-operation reset:** `rst` asserted at RUN cycle 4 → next cycle `busy`=0, `product`=0, no `done`. A fresh start with a=3, b=4 then gives 16'h000C.
